if_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the ID decoder.
- Owns the PC register and drives the instruction-ROM request.
- Holds the fetched word in a one-entry skid buffer while ID is stalled.
- Presents {pc, instruction, valid} to ID through the registered IF/ID boundary.
- Handles branch redirect with MIPS delay-slot semantics and exception flush.

---
 rtl/if_stage.sv | 131 +++++++++++++
 tb/tb_if_stage.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, ROM request, one-entry skid buffer and the
// registered IF/ID boundary, with delay-slot branch redirect and exception flush.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_addr_i,
   input  logic        flush_i,
   input  logic [31:0] new_pc_i,
   output logic        rom_ce_o,
   output logic [31:0] rom_addr_o,
   input  logic [31:0] rom_data_i,
   input  logic        rom_ready_i,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_inst_o,
   output logic        id_valid_o
);

   typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] buf_q, buf_d;
   logic        redir_pend_q, redir_pend_d;
   logic [31:0] redir_addr_q, redir_addr_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_inst_q, id_inst_d;
   logic        id_valid_q, id_valid_d;

   logic        take_branch;
   logic        deliver;
   logic [31:0] next_pc;

   // A branch is only sampled while ID is not stalled and no redirect is already pending.
   assign take_branch = branch_flag_i && !stall_i && !redir_pend_q;
   assign next_pc     = redir_pend_q ? redir_addr_q :
                        take_branch  ? branch_target_addr_i : pc_q + 32'd4;

   assign rom_ce_o   = (state_q == StFetch);
   assign rom_addr_o = pc_q;
   assign id_pc_o    = id_pc_q;
   assign id_inst_o  = id_inst_q;
   assign id_valid_o = id_valid_q;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      buf_d        = buf_q;
      redir_pend_d = redir_pend_q;
      redir_addr_d = redir_addr_q;
      id_pc_d      = id_pc_q;
      id_inst_d    = id_inst_q;
      id_valid_d   = id_valid_q;
      deliver      = 1'b0;

      if (flush_i) begin
         pc_d         = new_pc_i;
         buf_d        = 32'h0;
         redir_pend_d = 1'b0;
         id_pc_d      = 32'h0;
         id_inst_d    = 32'h0;
         id_valid_d   = 1'b0;
         state_d      = StFetch;
      end else begin
         unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
               if (!stall_i) begin
                  id_pc_d = pc_q;
                  if (rom_ready_i) begin
                     id_inst_d  = rom_data_i;
                     id_valid_d = 1'b1;
                     deliver    = 1'b1;
                  end else begin
                     id_inst_d  = 32'h0;
                     id_valid_d = 1'b0;
                  end
               end else if (rom_ready_i) begin
                  buf_d   = rom_data_i;
                  state_d = StHold;
               end
            end
            StHold: begin
               if (!stall_i) begin
                  id_pc_d    = pc_q;
                  id_inst_d  = buf_q;
                  id_valid_d = 1'b1;
                  deliver    = 1'b1;
                  state_d    = StFetch;
               end
            end
            default: state_d = StIdle;
         endcase

         // Delivering the word at pc completes any delay slot, so the redirect is consumed.
         if (deliver) begin
            pc_d         = next_pc;
            redir_pend_d = 1'b0;
         end else if (take_branch) begin
            redir_addr_d = branch_target_addr_i;
            redir_pend_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         pc_q         <= RESET_PC;
         buf_q        <= 32'h0;
         redir_pend_q <= 1'b0;
         redir_addr_q <= 32'h0;
         id_pc_q      <= 32'h0;
         id_inst_q    <= 32'h0;
         id_valid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         buf_q        <= buf_d;
         redir_pend_q <= redir_pend_d;
         redir_addr_q <= redir_addr_d;
         id_pc_q      <= id_pc_d;
         id_inst_q    <= id_inst_d;
         id_valid_q   <= id_valid_d;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: the driver queues the expected post-edge outputs for every
// cycle it drives, and a monitor pops and compares them just after each rising edge.
module tb_if_stage;

   typedef struct packed {
      logic        ce;
      logic [31:0] addr;
      logic [31:0] pc;
      logic [31:0] inst;
      logic        valid;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic        branch_flag_i;
   logic [31:0] branch_target_addr_i;
   logic        flush_i;
   logic [31:0] new_pc_i;
   logic        rom_ce_o;
   logic [31:0] rom_addr_o;
   logic [31:0] rom_data_i;
   logic        rom_ready_i;
   logic [31:0] id_pc_o;
   logic [31:0] id_inst_o;
   logic        id_valid_o;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fails  = 0;
   bit   done     = 1'b0;

   if_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .stall_i              (stall_i),
      .branch_flag_i        (branch_flag_i),
      .branch_target_addr_i (branch_target_addr_i),
      .flush_i              (flush_i),
      .new_pc_i             (new_pc_i),
      .rom_ce_o             (rom_ce_o),
      .rom_addr_o           (rom_addr_o),
      .rom_data_i           (rom_data_i),
      .rom_ready_i          (rom_ready_i),
      .id_pc_o              (id_pc_o),
      .id_inst_o            (id_inst_o),
      .id_valid_o           (id_valid_o)
   );

   always #5 clk = ~clk;

   assign rom_data_i = rom_addr_o ^ 32'hA5A5_0000;

   function automatic logic [31:0] d(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   function automatic exp_t mk(input logic ce, input logic [31:0] addr, input logic [31:0] pc,
                               input logic [31:0] inst, input logic valid);
      exp_t e;
      e.ce = ce; e.addr = addr; e.pc = pc; e.inst = inst; e.valid = valid;
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fails++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
      end
   endtask

   // One cycle: drive inputs at negedge, queue the outputs expected after the next edge.
   task automatic step(input logic r, input logic rdy, input logic stl, input logic br,
                       input logic [31:0] tgt, input logic fl, input logic [31:0] npc,
                       input exp_t e);
      @(negedge clk);
      rst = r; rom_ready_i = rdy; stall_i = stl; branch_flag_i = br;
      branch_target_addr_i = tgt; flush_i = fl; new_pc_i = npc;
      exp_q.push_back(e);
   endtask

   task automatic run(input logic rdy, input logic stl, input exp_t e);
      step(1'b0, rdy, stl, 1'b0, 32'h0, 1'b0, 32'h0, e);
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rom_ce",   {31'h0, rom_ce_o},   {31'h0, e.ce});
            check("rom_addr", rom_addr_o,          e.addr);
            check("id_pc",    id_pc_o,             e.pc);
            check("id_inst",  id_inst_o,           e.inst);
            check("id_valid", {31'h0, id_valid_o}, {31'h0, e.valid});
         end
      end
   end

   initial begin
      #20000;
      if (!done) begin
         $display("FAIL timeout: got running, expected finished");
         $fatal(1, "timeout");
      end
   end

   initial begin
      rst = 1'b1; rom_ready_i = 1'b0; stall_i = 1'b0; branch_flag_i = 1'b0;
      branch_target_addr_i = 32'h0; flush_i = 1'b0; new_pc_i = 32'h0;

      // Reset, dead IDLE cycle, then streaming 0, 4, 8
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, mk(1'b0, 32'h0, 32'h0, 32'h0, 1'b0));
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, mk(1'b0, 32'h0, 32'h0, 32'h0, 1'b0));
      run(1'b1, 1'b0, mk(1'b1, 32'h0, 32'h0, 32'h0, 1'b0));
      run(1'b1, 1'b0, mk(1'b1, 32'h4, 32'h0, d(32'h0), 1'b1));
      run(1'b1, 1'b0, mk(1'b1, 32'h8, 32'h4, d(32'h4), 1'b1));
      // ROM not ready for two cycles at 8: two bubbles
      run(1'b0, 1'b0, mk(1'b1, 32'h8, 32'h8, 32'h0, 1'b0));
      run(1'b0, 1'b0, mk(1'b1, 32'h8, 32'h8, 32'h0, 1'b0));
      run(1'b1, 1'b0, mk(1'b1, 32'hC, 32'h8, d(32'h8), 1'b1));
      // Stall three cycles with word C ready: HOLD, ce low, ID holds
      run(1'b1, 1'b1, mk(1'b0, 32'hC, 32'h8, d(32'h8), 1'b1));
      run(1'b0, 1'b1, mk(1'b0, 32'hC, 32'h8, d(32'h8), 1'b1));
      run(1'b0, 1'b1, mk(1'b0, 32'hC, 32'h8, d(32'h8), 1'b1));
      run(1'b0, 1'b0, mk(1'b1, 32'h10, 32'hC, d(32'hC), 1'b1));
      run(1'b1, 1'b0, mk(1'b1, 32'h14, 32'h10, d(32'h10), 1'b1));
      // Branch to 40 sampled while delay slot 14 is delivered
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0,
           mk(1'b1, 32'h40, 32'h14, d(32'h14), 1'b1));
      run(1'b1, 1'b0, mk(1'b1, 32'h44, 32'h40, d(32'h40), 1'b1));
      run(1'b1, 1'b0, mk(1'b1, 32'h48, 32'h44, d(32'h44), 1'b1));
      // Branch to 80 at pc 48 with ROM not ready; second branch while pending is ignored
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, mk(1'b1, 32'h48, 32'h48, 32'h0, 1'b0));
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h99C, 1'b0, 32'h0, mk(1'b1, 32'h48, 32'h48, 32'h0, 1'b0));
      run(1'b1, 1'b0, mk(1'b1, 32'h80, 32'h48, d(32'h48), 1'b1));
      run(1'b1, 1'b0, mk(1'b1, 32'h84, 32'h80, d(32'h80), 1'b1));
      // Pending redirect to 200, then HOLD, then flush to 180 with a competing branch
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0, mk(1'b1, 32'h84, 32'h84, 32'h0, 1'b0));
      run(1'b1, 1'b1, mk(1'b0, 32'h84, 32'h84, 32'h0, 1'b0));
      step(1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 1'b1, 32'h180,
           mk(1'b1, 32'h180, 32'h0, 32'h0, 1'b0));
      run(1'b1, 1'b0, mk(1'b1, 32'h184, 32'h180, d(32'h180), 1'b1));
      run(1'b1, 1'b0, mk(1'b1, 32'h188, 32'h184, d(32'h184), 1'b1));
      // Flush to top of address space, PC wraps to 0
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC,
           mk(1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0));
      run(1'b1, 1'b0, mk(1'b1, 32'h0, 32'hFFFF_FFFC, d(32'hFFFF_FFFC), 1'b1));
      run(1'b1, 1'b0, mk(1'b1, 32'h4, 32'h0, d(32'h0), 1'b1));
      // Reset overrides a simultaneous flush
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h500, mk(1'b0, 32'h0, 32'h0, 32'h0, 1'b0));
      run(1'b1, 1'b0, mk(1'b1, 32'h0, 32'h0, 32'h0, 1'b0));
      run(1'b1, 1'b0, mk(1'b1, 32'h4, 32'h0, d(32'h0), 1'b1));

      repeat (2) @(negedge clk);
      check("queue_drained", exp_q.size(), 32'd0);
      done = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
